adder_share_sched: RTL and testbench
====================================

Name: adder_share_sched

Overview:
- Time-shares one N-bit ripple adder datapath (operand conditioning plus full-adder chain) among NREQ requesters. Supported ops: add, subtract, two's-complement negate and pass.
- Arbitration is round-robin. The ripple chain is treated as a LAT-cycle multicycle path, with registered operands and a registered result.
- Sits between the ALU-side requesters and the shared adder core.

Parameters:
- N, 24, datapath width in bits.
- NREQ, 4, number of requesters; must be at least 2.
- LAT, 2, cycles allowed for ripple settle; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- op  in  2*NREQ  op of requester i in bits [2i+1:2i]: 00 ADD, 01 SUB, 10 NEG, 11 PASS.
- a_in  in  NREQ*N  operand A of requester i in bits [N*i+N-1:N*i].
- b_in  in  NREQ*N  operand B of requester i; ignored for NEG and PASS.
- gnt  out  NREQ  one-hot grant to the requester being served.
- done  out  1  one-cycle pulse; result is valid for done_id.
- done_id  out  clog2(NREQ)  index of the requester whose result is on result.
- result  out  N  registered result.
- cout  out  1  carry out of the MSB (for SUB, 1 = no borrow).
- ovf  out  1  signed two's-complement overflow.

Behaviour:
- Reset values: state IDLE, rr_ptr 0, gnt 0, done 0, done_id 0, result 0, cout 0, ovf 0, cycle counter 0.
- States are IDLE, EXEC and DONE.
- IDLE:
  - If req is nonzero, pick the first asserted requester scanning from rr_ptr upward, wrapping modulo NREQ.
  - Latch that requester's op, a_in and b_in into operand registers, set gnt to its one-hot, load counter with LAT-1, go to EXEC.
  - If req is zero, stay in IDLE with gnt 0.
- EXEC:
  - Operand registers are frozen and the adder core is driven from them.
  - Decrement the counter each cycle. At 0, register result, cout and ovf, set done_id, and go to DONE.
  - EXEC lasts exactly LAT cycles.
- DONE:
  - done is 1 for this single cycle; gnt is still held.
  - req is ignored in this cycle.
  - rr_ptr is set to (winner+1) mod NREQ. Next state is IDLE, with gnt and done cleared.
- Latency: req first seen high in IDLE at cycle t gives done high at cycle t+LAT+1. Back-to-back throughput is one op per LAT+2 cycles.
- Requester contract:
  - Hold req, op and operands stable from assertion until the done cycle addressed to it.
  - Deassert req at the edge ending that done cycle. A req still high in the following IDLE cycle is a new request.
- Arithmetic (all results modulo 2^N):
  - ADD: A+B with carry-in 0.
  - SUB: A + ~B + 1.
  - NEG: ~A + 1, with B forced to 0.
  - PASS: A + 0, carry-in 0; cout and ovf are 0.
- ovf:
  - ADD/SUB: operand-sign rule on the conditioned operands.
  - NEG: set only when A = 100..0 (the result equals A).
- result, cout and ovf hold their value until the next DONE.
- Reset asserted in any state aborts the operation: no done pulse, all outputs return to reset values on the next edge.
- Simultaneous requests: exactly one grant per arbitration; every continuously asserted requester is served within NREQ arbitrations.

Decomposition:
- Shared package holds:
  - the op encodings OP_ADD, OP_SUB, OP_NEG and OP_PASS;
  - the state encodings;
  - a clog2 function.
- Sub-module adder_core: combinational N-bit datapath.
  - Inputs: op, A, B. Outputs: sum, cout, ovf.
  - Structure: XOR-invert of B or A, carry-in select, then a chain of FullAdder cells.
- The scheduler instantiates exactly one adder_core.

Test Plan:
- Reset then idle: rst for 2 cycles with req=0 -> gnt=0, done=0 and result=0 hold for 10 cycles.
- Single ADD: req[1], A=0x00000F, B=0x000001 -> done at t+3 (LAT=2), done_id=1, result=0x000010, cout=0, ovf=0.
- Wrap and borrow cases:
  - ADD 0xFFFFFF+0x000001 -> result=0x000000, cout=1, ovf=0.
  - SUB 0x000001-0x000002 -> result=0xFFFFFF, cout=0, ovf=0.
- NEG edges:
  - A=0x000005 -> result=0xFFFFFB, ovf=0.
  - A=0x800000 -> result=0x800000, ovf=1.
- Contention: all 4 req high from reset with distinct ADDs, each dropping after its done -> done_id sequence 0,1,2,3 with correct sums; then re-raise req[0] and req[3] with rr_ptr=0 -> order 0,3.
- Reset mid-EXEC: rst asserted on the first EXEC cycle -> no done pulse; next cycle gnt=0, result=0, rr_ptr=0.

Source files
------------

// File: rtl/adder_share_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_share_sched_pkg
// Purpose : Shared op/state encodings and helpers for the shared-adder scheduler
// Revision: 1.0  initial release
// ============================================================================
package adder_share_sched_pkg;

   typedef logic [1:0] op_t;
   typedef logic [1:0] state_t;

   localparam op_t OP_ADD  = 2'b00;
   localparam op_t OP_SUB  = 2'b01;
   localparam op_t OP_NEG  = 2'b10;
   localparam op_t OP_PASS = 2'b11;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_EXEC = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : adder_share_sched_pkg
`default_nettype wire

// File: rtl/adder_share_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : adder_share_sched_if
// Purpose : Requester-side bus of the shared adder scheduler (requests, results)
// Revision: 1.0  initial release
// ============================================================================
interface adder_share_sched_if
   import adder_share_sched_pkg::*;
#(
   parameter int N    = 24,
   parameter int NREQ = 4,
   parameter int IDW  = clog2(NREQ)
) ();

   logic [NREQ-1:0]   req;
   logic [2*NREQ-1:0] op;
   logic [NREQ*N-1:0] a_in;
   logic [NREQ*N-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic              done;
   logic [IDW-1:0]    done_id;
   logic [N-1:0]      result;
   logic              cout;
   logic              ovf;

   modport master (
      output req, op, a_in, b_in,
      input  gnt, done, done_id, result, cout, ovf
   );

   modport slave (
      input  req, op, a_in, b_in,
      output gnt, done, done_id, result, cout, ovf
   );

endinterface : adder_share_sched_if
`default_nettype wire

// File: rtl/adder_share_sched_adder_core.sv
`default_nettype none
// ============================================================================
// Module  : adder_core (+ full_adder cell)
// Purpose : Combinational N-bit add/sub/neg/pass datapath over a ripple chain
// Revision: 1.0  initial release
// ============================================================================
module full_adder (
   input  wire logic i_a,
   input  wire logic i_b,
   input  wire logic i_c,
   output logic      o_s,
   output logic      o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule : full_adder

module adder_core
   import adder_share_sched_pkg::*;
#(
   parameter int N = 24
) (
   input  wire op_t        i_op,
   input  wire logic [N-1:0] i_a,
   input  wire logic [N-1:0] i_b,
   output logic [N-1:0]    o_sum,
   output logic            o_cout,
   output logic            o_ovf
);

   logic         w_inv_a;
   logic         w_inv_b;
   logic         w_use_b;
   logic         w_is_pass;
   logic [N-1:0] w_x;
   logic [N-1:0] w_y;
   logic [N:0]   w_c;
   logic [N-1:0] w_sum;

   assign w_inv_a   = (i_op == OP_NEG);
   assign w_inv_b   = (i_op == OP_SUB);
   assign w_use_b   = (i_op == OP_ADD) || (i_op == OP_SUB);
   assign w_is_pass = (i_op == OP_PASS);

   // NEG is ~A + 1 with B forced to zero; SUB is A + ~B + 1.
   assign w_x    = i_a ^ {N{w_inv_a}};
   assign w_y    = (w_use_b ? i_b : '0) ^ {N{w_inv_b}};
   assign w_c[0] = w_inv_a | w_inv_b;

   for (genvar i = 0; i < N; i++) begin : g_fa
      full_adder u_fa (
         .i_a (w_x[i]),
         .i_b (w_y[i]),
         .i_c (w_c[i]),
         .o_s (w_sum[i]),
         .o_c (w_c[i+1])
      );
   end

   assign o_sum  = w_sum;
   assign o_cout = w_is_pass ? 1'b0 : w_c[N];
   // Sign rule on the conditioned operands; also yields NEG overflow for A = 100..0.
   assign o_ovf  = w_is_pass ? 1'b0
                 : ((w_x[N-1] == w_y[N-1]) && (w_sum[N-1] != w_x[N-1]));

endmodule : adder_core
`default_nettype wire

// File: rtl/adder_share_sched.sv
`default_nettype none
// ============================================================================
// Module  : adder_share_sched
// Purpose : Round-robin scheduler time-sharing one ripple adder as a LAT-cycle path
// Revision: 1.0  initial release
// ============================================================================
module adder_share_sched
   import adder_share_sched_pkg::*;
#(
   parameter int N    = 24,
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   adder_share_sched_if.slave bus
);

   localparam int IDW = clog2(NREQ);
   localparam int CW  = (LAT > 1) ? clog2(LAT) : 1;

   state_t          r_state;
   state_t          w_next;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_win;
   op_t             r_op;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_result;
   logic            r_cout;
   logic            r_ovf;
   logic [IDW-1:0]  r_done_id;

   logic            w_found;
   logic [IDW-1:0]  w_pick;
   logic [IDW-1:0]  w_scan;
   op_t             w_sel_op;
   logic [N-1:0]    w_sel_a;
   logic [N-1:0]    w_sel_b;
   logic [N-1:0]    w_sum;
   logic            w_cout;
   logic            w_ovf;

   // Round-robin pick: first asserted request at or above r_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_scan  = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_scan = IDW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && bus.req[w_scan]) begin
            w_found = 1'b1;
            w_pick  = w_scan;
         end
      end
   end

   always_comb begin
      w_sel_op = bus.op[2*int'(w_pick) +: 2];
      w_sel_a  = bus.a_in[N*int'(w_pick) +: N];
      w_sel_b  = bus.b_in[N*int'(w_pick) +: N];
   end

   adder_core #(
      .N (N)
   ) u_core (
      .i_op   (r_op),
      .i_a    (r_a),
      .i_b    (r_b),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_found) w_next = ST_EXEC;
         ST_EXEC: if (r_cnt == '0) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Operands stay frozen through EXEC so the ripple chain sees stable inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_win     <= '0;
         r_op      <= OP_ADD;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_result  <= '0;
         r_cout    <= 1'b0;
         r_ovf     <= 1'b0;
         r_done_id <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_win <= w_pick;
                  r_op  <= w_sel_op;
                  r_a   <= w_sel_a;
                  r_b   <= w_sel_b;
                  r_cnt <= CW'(LAT - 1);
               end
            end
            ST_EXEC: begin
               if (r_cnt == '0) begin
                  r_result  <= w_sum;
                  r_cout    <= w_cout;
                  r_ovf     <= w_ovf;
                  r_done_id <= r_win;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               r_ptr <= (r_win == IDW'(NREQ - 1)) ? '0 : r_win + 1'b1;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.gnt  = '0;
      bus.done = 1'b0;
      if (r_state != ST_IDLE) begin
         bus.gnt = NREQ'(1) << r_win;
      end
      if (r_state == ST_DONE) begin
         bus.done = 1'b1;
      end
   end

   assign bus.done_id = r_done_id;
   assign bus.result  = r_result;
   assign bus.cout    = r_cout;
   assign bus.ovf     = r_ovf;

endmodule : adder_share_sched
`default_nettype wire

// File: tb/tb_adder_share_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_share_sched
// Purpose : Scoreboard bench for adder_share_sched with an arithmetic reference model
// Revision: 1.0  initial release
// ============================================================================
module tb_adder_share_sched;
   import adder_share_sched_pkg::*;

   localparam int N    = 24;
   localparam int NREQ = 4;
   localparam int LAT  = 2;
   localparam int IDW  = 2;

   typedef struct {
      int           id;
      logic [N-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NREQ-1:0]   req_v = '0;
   logic [2*NREQ-1:0] op_v  = '0;
   logic [NREQ*N-1:0] a_v   = '0;
   logic [NREQ*N-1:0] b_v   = '0;

   adder_share_sched_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();
   assign bus.req  = req_v;
   assign bus.op   = op_v;
   assign bus.a_in = a_v;
   assign bus.b_in = b_v;

   adder_share_sched #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   exp_t         sb[$];
   int           done_log[$];
   int           busy   = 0;
   int           mptr   = 0;
   int           mwin   = 0;
   bit           mvalid = 1'b0;
   logic [N-1:0] hold_res = '0;
   logic         hold_co  = 1'b0;
   logic         hold_ov  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic on plain integers, independent of any adder structure.
   function automatic exp_t ref_op(input int id, input logic [1:0] op,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
      exp_t   e;
      longint m, h, ua, ub, sa, sb_, r, ss;
      m  = longint'(1) << N;
      h  = m / 2;
      ua = longint'(a);
      ub = longint'(b);
      sa = (ua >= h) ? ua - m : ua;
      sb_ = (ub >= h) ? ub - m : ub;
      e.id = id;
      e.co = 1'b0;
      e.ov = 1'b0;
      r    = ua;
      case (op)
         OP_ADD: begin
            r = ua + ub; e.co = (r >= m); r = r % m;
            ss = sa + sb_; e.ov = (ss >= h) || (ss < -h);
         end
         OP_SUB: begin
            r = (ua - ub + m) % m; e.co = (ua >= ub);
            ss = sa - sb_; e.ov = (ss >= h) || (ss < -h);
         end
         OP_NEG: begin
            r = (m - ua) % m; e.co = (ua == 0);
            ss = -sa; e.ov = (ss >= h);
         end
         default: r = ua;
      endcase
      e.res = N'(r);
      return e;
   endfunction

   // Transaction-level model: one request in flight for LAT+1 cycles after its pick.
   always @(posedge clk) begin
      if (rst) begin
         busy = 0; mptr = 0; mvalid = 1'b1;
         sb.delete();
         hold_res = '0; hold_co = 1'b0; hold_ov = 1'b0;
      end else if (mvalid) begin
         if (busy > 0) begin
            busy--;
            if (busy == 0) mptr = (mwin + 1) % NREQ;
         end else if (req_v != '0) begin
            for (int k = 0; k < NREQ; k++) begin
               if (busy == 0 && req_v[(mptr + k) % NREQ]) begin
                  mwin = (mptr + k) % NREQ;
                  busy = LAT + 1;
               end
            end
            sb.push_back(ref_op(mwin, op_v[2*mwin +: 2], a_v[N*mwin +: N], b_v[N*mwin +: N]));
         end
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (mvalid) begin
         chk("done", bus.done, busy == 1);
         chk("gnt", bus.gnt, (busy > 0) ? (64'd1 << mwin) : 64'd0);
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("done_id", bus.done_id, e.id);
               chk("result", bus.result, e.res);
               chk("cout", bus.cout, e.co);
               chk("ovf", bus.ovf, e.ov);
               hold_res = e.res; hold_co = e.co; hold_ov = e.ov;
               done_log.push_back(int'(bus.done_id));
            end
         end else begin
            chk("hold_result", bus.result, hold_res);
            chk("hold_cout", bus.cout, hold_co);
            chk("hold_ovf", bus.ovf, hold_ov);
         end
         if (busy == 1) req_v[mwin] = 1'b0;
      end
   end

   task automatic set_req(input int i, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b);
      op_v[2*i +: 2] = op;
      a_v[N*i +: N]  = a;
      b_v[N*i +: N]  = b;
      req_v[i]       = 1'b1;
   endtask

   task automatic wait_clear(input logic [NREQ-1:0] mask, input int budget);
      int n;
      n = 0;
      while ((req_v & mask) != '0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if ((req_v & mask) != '0) chk("timeout", req_v, 0);
      @(negedge clk);
   endtask

   task automatic run1(input int i, input logic [1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b);
      @(negedge clk);
      set_req(i, op, a, b);
      wait_clear(NREQ'(1) << i, 20);
   endtask

   logic [NREQ*N-1:0] rnd_v;
   int lat_n;

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_done_id", bus.done_id, 0);
      chk("rst_cout", bus.cout, 0);

      set_req(1, OP_ADD, 24'h00000F, 24'h000001);
      lat_n = 0;
      while (bus.done !== 1'b1 && lat_n < 10) begin
         @(negedge clk);
         lat_n++;
      end
      chk("latency", lat_n, LAT + 1);
      chk("add_res", bus.result, 24'h000010);
      wait_clear('1, 20);

      run1(2, OP_ADD, 24'hFFFFFF, 24'h000001);
      chk("wrap_res", bus.result, 24'h000000);
      chk("wrap_cout", bus.cout, 1);
      run1(0, OP_SUB, 24'h000001, 24'h000002);
      chk("borrow_res", bus.result, 24'hFFFFFF);
      chk("borrow_cout", bus.cout, 0);
      run1(3, OP_NEG, 24'h000005, 24'h123456);
      chk("neg5_res", bus.result, 24'hFFFFFB);
      run1(1, OP_NEG, 24'h800000, 24'h000000);
      chk("negmin_res", bus.result, 24'h800000);
      chk("negmin_ovf", bus.ovf, 1);
      run1(2, OP_PASS, 24'h123456, 24'hFFFFFF);
      run1(0, OP_ADD, 24'h7FFFFF, 24'h000001);
      chk("addovf_ovf", bus.ovf, 1);

      // Contention straight out of reset, then a 0/3 pair from pointer 0.
      rst = 1'b1;
      req_v = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      done_log.delete();
      for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 24'(100 * (i + 1)), 24'(i + 7));
      wait_clear('1, 60);
      set_req(0, OP_ADD, 24'h000011, 24'h000022);
      set_req(3, OP_ADD, 24'h000033, 24'h000044);
      wait_clear('1, 40);
      chk("order_len", done_log.size(), 6);
      if (done_log.size() == 6) begin
         chk("order0", done_log[0], 0);
         chk("order1", done_log[1], 1);
         chk("order2", done_log[2], 2);
         chk("order3", done_log[3], 3);
         chk("order4", done_log[4], 0);
         chk("order5", done_log[5], 3);
      end

      // Reset on the first EXEC cycle of a request from requester 2.
      set_req(2, OP_ADD, 24'h000001, 24'h000001);
      lat_n = 0;
      while (busy != LAT + 1 && lat_n < 10) begin
         @(negedge clk);
         lat_n++;
      end
      chk("exec_reached", busy, LAT + 1);
      rst = 1'b1;
      req_v = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_gnt", bus.gnt, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_res", bus.result, 0);
      done_log.delete();
      set_req(1, OP_SUB, 24'h000009, 24'h000003);
      set_req(3, OP_SUB, 24'h000005, 24'h000009);
      wait_clear('1, 40);
      chk("abort_ptr", (done_log.size() > 0) ? done_log[0] : -1, 1);

      // Random traffic with corner-biased operands.
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (!req_v[i] && $urandom_range(3) == 0) begin
               rnd_v[N-1:0]   = ($urandom_range(4) == 0) ? 24'h800000 : 24'($urandom);
               rnd_v[2*N-1:N] = ($urandom_range(4) == 0) ? 24'hFFFFFF : 24'($urandom);
               set_req(i, 2'($urandom_range(3)), rnd_v[N-1:0], rnd_v[2*N-1:N]);
            end
         end
      end
      wait_clear('1, 200);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule : tb_adder_share_sched
`default_nettype wire
